// File: rtl/id_hazard_scoreboard.sv
// Load-use hazard scoreboard for the ID stage: per-register countdown until a pending
// result is forwardable, stall/bubble generation and a saturating stall-cycle counter.
module id_hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned LAT_W    = 2,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ID_Flush,
    input  logic                     Pipe_Hold,
    input  logic [NUM_RD-1:0]        ID_RdEn,
    input  logic [NUM_RD*REG_AW-1:0] ID_RdAddr,
    input  logic                     ID_Issue,
    input  logic                     ID_IssueWr,
    input  logic [REG_AW-1:0]        ID_IssueDst,
    input  logic [LAT_W-1:0]         ID_IssueLat,
    output logic                     DH_IDWr,
    output logic                     DH_PCWr,
    output logic                     EXE_Flush_DataHazard,
    output logic                     DH_Stall,
    output logic [PERF_W-1:0]        DH_StallCycles
);

    // Register 0 is hard-wired zero, so it gets no counter at all.
    logic [LAT_W-1:0]  cnt_q [1:NUM_REGS-1];
    logic [LAT_W-1:0]  cnt_d [1:NUM_REGS-1];
    logic [PERF_W-1:0] perf_q;
    logic [PERF_W-1:0] perf_d;
    logic [NUM_RD-1:0] port_hit;
    logic              stall;
    logic              fire;
    logic              issue_wr_valid;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [REG_AW-1:0] rd_addr;
        logic              hit;

        assign rd_addr = ID_RdAddr[i*REG_AW +: REG_AW];

        always_comb begin
            hit = 1'b0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (rd_addr == REG_AW'(r) && cnt_q[r] != '0) begin
                    hit = 1'b1;
                end
            end
        end

        assign port_hit[i] = ID_RdEn[i] && hit;
    end

    assign stall          = |port_hit;
    assign fire           = ID_Issue && !stall && !Pipe_Hold && !ID_Flush;
    assign issue_wr_valid = fire && ID_IssueWr && (ID_IssueDst != '0);

    always_comb begin
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        perf_d = perf_q;

        if (ID_Flush) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                cnt_d[r] = '0;
            end
            // A flushed cycle that was stalling still counts as a lost cycle.
            if (stall && perf_q != '1) begin
                perf_d = perf_q + PERF_W'(1);
            end
        end else if (!Pipe_Hold) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LAT_W'(1);
                end
                if (issue_wr_valid && ID_IssueDst == REG_AW'(r)) begin
                    cnt_d[r] = ID_IssueLat;
                end
            end
            if (stall && perf_q != '1) begin
                perf_d = perf_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            perf_q <= '0;
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            perf_q <= perf_d;
        end
    end

    assign DH_Stall             = stall;
    assign DH_IDWr              = !stall;
    assign DH_PCWr              = !stall;
    assign EXE_Flush_DataHazard = stall;
    assign DH_StallCycles       = perf_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed-vector bench: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_Flush;
    logic        Pipe_Hold;
    logic [1:0]  ID_RdEn;
    logic [9:0]  ID_RdAddr;
    logic        ID_Issue;
    logic        ID_IssueWr;
    logic [4:0]  ID_IssueDst;
    logic [1:0]  ID_IssueLat;

    logic        idwr, pcwr, exe_flush, stall;
    logic [31:0] perf;
    logic        idwr4, pcwr4, exe_flush4, stall4;
    logic [3:0]  perf4;

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .ID_Flush(ID_Flush), .Pipe_Hold(Pipe_Hold),
        .ID_RdEn(ID_RdEn), .ID_RdAddr(ID_RdAddr), .ID_Issue(ID_Issue),
        .ID_IssueWr(ID_IssueWr), .ID_IssueDst(ID_IssueDst), .ID_IssueLat(ID_IssueLat),
        .DH_IDWr(idwr), .DH_PCWr(pcwr), .EXE_Flush_DataHazard(exe_flush),
        .DH_Stall(stall), .DH_StallCycles(perf)
    );

    id_hazard_scoreboard #(.PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .ID_Flush(ID_Flush), .Pipe_Hold(Pipe_Hold),
        .ID_RdEn(ID_RdEn), .ID_RdAddr(ID_RdAddr), .ID_Issue(ID_Issue),
        .ID_IssueWr(ID_IssueWr), .ID_IssueDst(ID_IssueDst), .ID_IssueLat(ID_IssueLat),
        .DH_IDWr(idwr4), .DH_PCWr(pcwr4), .EXE_Flush_DataHazard(exe_flush4),
        .DH_Stall(stall4), .DH_StallCycles(perf4)
    );

    typedef struct packed {
        logic        stall;
        logic [31:0] perf;
        logic [3:0]  perf4;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    int    errors = 0;
    int    checks = 0;
    int unsigned mp  = 0;
    logic [3:0]  mp4 = '0;

    task automatic chk(input string nm, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (eq.size() > 0) begin
            exp_t  e;
            string n;
            e = eq.pop_front();
            n = nq.pop_front();
            chk(n, "stall",     {31'd0, stall},     {31'd0, e.stall});
            chk(n, "idwr",      {31'd0, idwr},      {31'd0, !e.stall});
            chk(n, "pcwr",      {31'd0, pcwr},      {31'd0, !e.stall});
            chk(n, "exe_flush", {31'd0, exe_flush}, {31'd0, e.stall});
            chk(n, "perf",      perf,               e.perf);
            chk(n, "stall4",    {31'd0, stall4},    {31'd0, e.stall});
            chk(n, "perf4",     {28'd0, perf4},     {28'd0, e.perf4});
        end
    end

    // One ID cycle: drive inputs, queue the expected response, advance the perf model.
    task automatic cyc(input logic iss, input logic wr, input logic [4:0] dst,
                       input logic [1:0] lat, input logic [1:0] rden,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic hold, input logic flush, input logic r,
                       input logic es, input string nm);
        exp_t e;
        ID_Issue    = iss;
        ID_IssueWr  = wr;
        ID_IssueDst = dst;
        ID_IssueLat = lat;
        ID_RdEn     = rden;
        ID_RdAddr   = {a1, a0};
        Pipe_Hold   = hold;
        ID_Flush    = flush;
        rst         = r;
        e.stall = es;
        e.perf  = mp;
        e.perf4 = mp4;
        eq.push_back(e);
        nq.push_back(nm);
        if (r) begin
            mp  = 0;
            mp4 = '0;
        end else if ((flush || !hold) && es) begin
            mp++;
            if (mp4 != 4'hF) mp4++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic iss_w(input logic [4:0] dst, input logic [1:0] lat, input string nm);
        cyc(1'b1, 1'b1, dst, lat, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic rd(input logic [1:0] rden, input logic [4:0] a0, input logic [4:0] a1,
                      input logic es, input string nm);
        cyc(1'b1, 1'b0, 5'd0, 2'd0, rden, a0, a1, 1'b0, 1'b0, 1'b0, es, nm);
    endtask

    task automatic idle(input string nm);
        cyc(1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    initial begin
        rst = 1'b1; ID_Flush = 1'b0; Pipe_Hold = 1'b0; ID_RdEn = '0; ID_RdAddr = '0;
        ID_Issue = 1'b0; ID_IssueWr = 1'b0; ID_IssueDst = '0; ID_IssueLat = '0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
        idle("post_reset");

        // Classic load-use: one bubble
        iss_w(5'd5, 2'd1, "lu_issue");
        rd(2'b01, 5'd5, 5'd0, 1'b1, "lu_stall");
        rd(2'b01, 5'd5, 5'd0, 1'b0, "lu_go");
        idle("lu_idle");

        // Latency 3 on port 1, then same with read enables off
        iss_w(5'd7, 2'd3, "l3_issue");
        rd(2'b10, 5'd0, 5'd7, 1'b1, "l3_stall1");
        rd(2'b10, 5'd0, 5'd7, 1'b1, "l3_stall2");
        rd(2'b10, 5'd0, 5'd7, 1'b1, "l3_stall3");
        rd(2'b10, 5'd0, 5'd7, 1'b0, "l3_go");
        iss_w(5'd7, 2'd3, "l3n_issue");
        for (int k = 0; k < 4; k++) rd(2'b00, 5'd7, 5'd7, 1'b0, "l3_noread");

        // Pipe_Hold freezes countdown and perf counter
        iss_w(5'd7, 2'd3, "hold_issue");
        rd(2'b10, 5'd0, 5'd7, 1'b1, "hold_pre");
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 1'b0, 5'd0, 2'd0, 2'b10, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, "hold_frozen");
        rd(2'b10, 5'd0, 5'd7, 1'b1, "hold_post1");
        rd(2'b10, 5'd0, 5'd7, 1'b1, "hold_post2");
        rd(2'b10, 5'd0, 5'd7, 1'b0, "hold_go");

        // An issue presented during hold must not create an entry
        cyc(1'b1, 1'b1, 5'd9, 2'd3, 2'b00, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_iss");
        rd(2'b01, 5'd9, 5'd0, 1'b0, "hold_noentry");

        // Flush clears pending entries; stall during flush is still counted
        iss_w(5'd3, 2'd3, "fl_issue");
        cyc(1'b1, 1'b0, 5'd0, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, "fl_cycle");
        rd(2'b01, 5'd3, 5'd0, 1'b0, "fl_after");

        // Reset mid-countdown
        iss_w(5'd3, 2'd3, "rs_issue");
        cyc(1'b1, 1'b0, 5'd0, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "rs_cycle");
        rd(2'b01, 5'd3, 5'd0, 1'b0, "rs_after");

        // r0 is never tracked
        iss_w(5'd0, 2'd3, "r0_issue");
        rd(2'b11, 5'd0, 5'd0, 1'b0, "r0_read1");
        rd(2'b11, 5'd0, 5'd0, 1'b0, "r0_read2");

        // Later writer wins: lat 3 then lat 1 to r4
        iss_w(5'd4, 2'd3, "bb_issue3");
        iss_w(5'd4, 2'd1, "bb_issue1");
        rd(2'b01, 5'd4, 5'd0, 1'b1, "bb_stall");
        rd(2'b01, 5'd4, 5'd0, 1'b0, "bb_go");

        // Latency 0 creates no entry
        iss_w(5'd6, 2'd0, "l0_issue");
        rd(2'b10, 5'd0, 5'd6, 1'b0, "l0_read");

        // Issuer reading its own destination sees only the old count
        cyc(1'b1, 1'b1, 5'd8, 2'd2, 2'b01, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "self_first");
        cyc(1'b1, 1'b1, 5'd8, 2'd2, 2'b01, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "self_stall1");
        cyc(1'b1, 1'b1, 5'd8, 2'd2, 2'b01, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "self_stall2");
        cyc(1'b1, 1'b1, 5'd8, 2'd2, 2'b01, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "self_go");
        idle("self_drain1");
        idle("self_drain2");

        // Enough stalls to saturate the 4-bit counter instance
        for (int k = 0; k < 5; k++) begin
            iss_w(5'd10, 2'd3, "sat_issue");
            for (int j = 0; j < 3; j++) rd(2'b01, 5'd10, 5'd0, 1'b1, "sat_stall");
        end
        idle("sat_end1");
        idle("sat_end2");

        @(negedge clk);
        #1;
        chk("drain", "pending", eq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
